// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - LC-3b style memory port bundle shared by requesters and memory
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int BE_W   = 2
);
    logic              read;
    logic              write;
    logic [BE_W-1:0]   byte_enable;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              resp;

    // Side that issues requests (CPU requester, or the arbiter toward memory)
    modport master (
        output read, write, byte_enable, address, wdata,
        input  rdata, resp
    );

    // Side that serves requests (memory, or the arbiter toward a requester)
    modport slave (
        input  read, write, byte_enable, address, wdata,
        output rdata, resp
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin I/D arbiter for one memory port; optional watchdog via MEM_ARB_TIMEOUT_EN
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int BE_W   = 2
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.slave   i_bus,
    mem_arbiter_if.slave   d_bus,
    mem_arbiter_if.master  mem_bus
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    output logic           timeout_err
`endif
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t state;
    // 1 when D owned the most recent grant, so I wins the next tie
    logic   last_grant_d;
    logic   i_req;
    logic   d_req;
    logic   own_i;
    logic   own_d;

    assign i_req = i_bus.read;
    assign d_req = d_bus.read | d_bus.write;

    // Reset overrides the passthrough so a grant being torn down never leaks out
    assign own_i = (state == GRANT_I) && !reset;
    assign own_d = (state == GRANT_D) && !reset;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] wait_cnt;
`endif

    // Arbitration FSM: pick a side in IDLE, hold the grant until memory answers
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last_grant_d <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt     <= '0;
            timeout_err  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    if (i_req && (!d_req || last_grant_d)) begin
                        state        <= GRANT_I;
                        last_grant_d <= 1'b0;
                    end else if (d_req) begin
                        state        <= GRANT_D;
                        last_grant_d <= 1'b1;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (mem_bus.resp) begin
                        state <= IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Memory never answered: drop the grant silently and flag it
                        state       <= IDLE;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Route the owning requester to memory and memory's answer back to the owner only
    always_comb begin
        mem_bus.read        = 1'b0;
        mem_bus.write       = 1'b0;
        mem_bus.byte_enable = '0;
        mem_bus.address     = '0;
        mem_bus.wdata       = '0;
        i_bus.resp          = 1'b0;
        i_bus.rdata         = '0;
        d_bus.resp          = 1'b0;
        d_bus.rdata         = '0;
        if (own_i) begin
            mem_bus.read        = i_bus.read;
            mem_bus.byte_enable = '1;
            mem_bus.address     = i_bus.address;
            i_bus.resp          = mem_bus.resp;
            i_bus.rdata         = mem_bus.rdata;
        end else if (own_d) begin
            mem_bus.read        = d_bus.read;
            mem_bus.write       = d_bus.write;
            mem_bus.byte_enable = d_bus.byte_enable;
            mem_bus.address     = d_bus.address;
            mem_bus.wdata       = d_bus.wdata;
            d_bus.resp          = mem_bus.resp;
            d_bus.rdata         = mem_bus.rdata;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16), .BE_W(2)) i_bus ();
    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16), .BE_W(2)) d_bus ();
    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16), .BE_W(2)) mem_bus ();

`ifdef MEM_ARB_TIMEOUT_EN
    logic timeout_err;
    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .BE_W(2), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .i_bus(i_bus), .d_bus(d_bus), .mem_bus(mem_bus),
        .timeout_err(timeout_err)
    );
`else
    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .BE_W(2)) dut (
        .clk(clk), .reset(reset), .i_bus(i_bus), .d_bus(d_bus), .mem_bus(mem_bus)
    );
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        i_bus.read = 0; i_bus.write = 0; i_bus.byte_enable = 0; i_bus.address = 0; i_bus.wdata = 0;
        d_bus.read = 0; d_bus.write = 0; d_bus.byte_enable = 0; d_bus.address = 0; d_bus.wdata = 0;
        mem_bus.rdata = 0; mem_bus.resp = 0;
        tick;
        tick;
        #2;
        check("rst_mem_read",  32'(mem_bus.read), 0);
        check("rst_mem_write", 32'(mem_bus.write), 0);
        check("rst_mem_be",    32'(mem_bus.byte_enable), 0);
        check("rst_mem_addr",  32'(mem_bus.address), 0);
        check("rst_i_resp",    32'(i_bus.resp), 0);
        check("rst_d_resp",    32'(d_bus.resp), 0);

        // I-only fetch, memory answers on the 3rd grant cycle
        reset = 0; i_bus.read = 1; i_bus.address = 16'h0060;
        #2 check("ifetch_idle_read", 32'(mem_bus.read), 0);
        tick; #2;
        check("ifetch_c1_read", 32'(mem_bus.read), 1);
        check("ifetch_c1_addr", 32'(mem_bus.address), 32'h0060);
        check("ifetch_c1_be",   32'(mem_bus.byte_enable), 3);
        check("ifetch_c1_wr",   32'(mem_bus.write), 0);
        check("ifetch_c1_resp", 32'(i_bus.resp), 0);
        tick; #2;
        check("ifetch_c2_read", 32'(mem_bus.read), 1);
        tick; mem_bus.resp = 1; mem_bus.rdata = 16'h1234; #2;
        check("ifetch_c3_iresp",  32'(i_bus.resp), 1);
        check("ifetch_c3_irdata", 32'(i_bus.rdata), 32'h1234);
        check("ifetch_c3_dresp",  32'(d_bus.resp), 0);

        // Back in IDLE: stray mem_resp ignored; D write is requested here
        tick; i_bus.read = 0; mem_bus.resp = 1;
        d_bus.write = 1; d_bus.address = 16'h0100; d_bus.wdata = 16'hBEEF; d_bus.byte_enable = 2'b01;
        #2;
        check("idle_mem_read",   32'(mem_bus.read), 0);
        check("idle_stray_iresp", 32'(i_bus.resp), 0);
        check("idle_stray_dresp", 32'(d_bus.resp), 0);
        tick; mem_bus.resp = 0; #2;
        check("dwr_write", 32'(mem_bus.write), 1);
        check("dwr_read",  32'(mem_bus.read), 0);
        check("dwr_addr",  32'(mem_bus.address), 32'h0100);
        check("dwr_wdata", 32'(mem_bus.wdata), 32'hBEEF);
        check("dwr_be",    32'(mem_bus.byte_enable), 32'h1);
        check("dwr_noresp", 32'(d_bus.resp), 0);
        tick; mem_bus.resp = 1; #2;
        check("dwr_dresp", 32'(d_bus.resp), 1);
        check("dwr_iresp", 32'(i_bus.resp), 0);
        tick; mem_bus.resp = 0; d_bus.write = 0; #2;
        check("dwr_after_dresp", 32'(d_bus.resp), 0);
        check("dwr_after_write", 32'(mem_bus.write), 0);

        // Simultaneous requests right after reset: I first, then D
        reset = 1;
        tick;
        reset = 0;
        i_bus.read = 1; i_bus.address = 16'h0200;
        d_bus.read = 1; d_bus.address = 16'h0300; d_bus.byte_enable = 2'b11;
        tick; mem_bus.resp = 1; mem_bus.rdata = 16'hAAAA; #2;
        check("sim_first_addr", 32'(mem_bus.address), 32'h0200);
        check("sim_first_iresp", 32'(i_bus.resp), 1);
        check("sim_first_irdata", 32'(i_bus.rdata), 32'hAAAA);
        check("sim_first_dresp", 32'(d_bus.resp), 0);
        tick; mem_bus.resp = 0; i_bus.read = 0; #2;
        check("sim_dead_read", 32'(mem_bus.read), 0);
        tick; mem_bus.resp = 1; mem_bus.rdata = 16'h5555; #2;
        check("sim_second_addr", 32'(mem_bus.address), 32'h0300);
        check("sim_second_dresp", 32'(d_bus.resp), 1);
        check("sim_second_drdata", 32'(d_bus.rdata), 32'h5555);
        check("sim_second_iresp", 32'(i_bus.resp), 0);

        // Continuous contention: six grants alternate I, D, I, D, I, D
        tick; mem_bus.resp = 0;
        i_bus.read = 1; i_bus.address = 16'h0400;
        d_bus.read = 1; d_bus.address = 16'h0500;
        for (int k = 0; k < 6; k++) begin
            tick; mem_bus.resp = 1; #2;
            check($sformatf("rr%0d_addr", k), 32'(mem_bus.address), (k % 2 == 0) ? 32'h0400 : 32'h0500);
            check($sformatf("rr%0d_iresp", k), 32'(i_bus.resp), (k % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("rr%0d_dresp", k), 32'(d_bus.resp), (k % 2 == 0) ? 32'd0 : 32'd1);
            tick; mem_bus.resp = 0; #2;
            check($sformatf("rr%0d_idle", k), 32'(mem_bus.read), 0);
        end
        i_bus.read = 0; d_bus.read = 0;

        // Reset in the middle of a D grant, then a late mem_resp
        tick;
        d_bus.read = 1; d_bus.address = 16'h0700;
        tick; #2;
        check("rstmid_grant_read", 32'(mem_bus.read), 1);
        check("rstmid_grant_addr", 32'(mem_bus.address), 32'h0700);
        tick; reset = 1;
        tick; reset = 0; d_bus.read = 0; #2;
        check("rstmid_read",  32'(mem_bus.read), 0);
        check("rstmid_addr",  32'(mem_bus.address), 0);
        check("rstmid_dresp", 32'(d_bus.resp), 0);
        mem_bus.resp = 1; #1;
        check("rstmid_late_dresp", 32'(d_bus.resp), 0);
        check("rstmid_late_iresp", 32'(i_bus.resp), 0);
        tick; #2;
        check("rstmid_late2_dresp", 32'(d_bus.resp), 0);
        check("rstmid_late2_read",  32'(mem_bus.read), 0);
        mem_bus.resp = 0;

`ifdef MEM_ARB_TIMEOUT_EN
        // Withheld mem_resp: grant dropped after 4 cycles, sticky error
        tick;
        check("to_err_clear", 32'(timeout_err), 0);
        i_bus.read = 1; i_bus.address = 16'h0900;
        for (int c = 0; c < 4; c++) begin
            tick; #2;
            check($sformatf("to_c%0d_read", c), 32'(mem_bus.read), 1);
            check($sformatf("to_c%0d_iresp", c), 32'(i_bus.resp), 0);
        end
        i_bus.read = 0;
        tick; #2;
        check("to_idle_read", 32'(mem_bus.read), 0);
        check("to_err_set", 32'(timeout_err), 1);
        check("to_iresp", 32'(i_bus.resp), 0);
        tick; tick; #2;
        check("to_err_sticky", 32'(timeout_err), 1);
        reset = 1;
        tick; reset = 0; #2;
        check("to_err_reset", 32'(timeout_err), 0);
`endif

        tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
